mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 15, max consecutive ACC cycles without ram_ready before abort (used only with ARB_TIMEOUT_EN).
REQ-002 CLK  input  1  system clock; all state updates on rising edge.
REQ-003 nRST  input  1  reset, asynchronous, active-low.
REQ-004 iREN  input  1  instruction fetch request; held high until ihit.
REQ-005 iaddr  input  32  instruction word address.
REQ-006 dREN  input  1  data read request; held high until dhit.
REQ-007 dWEN  input  1  data write request; held high until dhit; never high with dREN.
REQ-008 daddr  input  32  data word address.
REQ-009 dstore  input  32  write data.
REQ-010 ram_ready  input  1  single-port RAM completes current access this cycle.
REQ-011 ramload  input  32  RAM read data, valid when ram_ready.
REQ-012 ramREN, ramWEN  output  1 each  RAM read / write strobes.
REQ-013 ramaddr, ramstore  output  32 each  RAM address / write data.
REQ-014 ihit, dhit  output  1 each  one-cycle completion pulse per requester.
REQ-015 iload, dload  output  32 each  registered read data for each requester.
REQ-016 err  output  1  sticky access-timeout flag.

Function
REQ-017 States SHALL be IDLE, IACC, DACC, encoded in a 2-bit register.
REQ-018 IDLE: (dREN|dWEN) -> DACC; else iREN -> IACC; else stay IDLE. Data SHALL win simultaneous requests.
REQ-019 IACC SHALL drive ramREN=1, ramaddr=iaddr; DACC SHALL drive ramREN=dREN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore; IDLE SHALL drive all RAM outputs 0.
REQ-020 On ram_ready in IACC: iload<=ramload, ihit<=1 next cycle, state->IDLE; DACC likewise with dload/dhit (dload updated only for reads).
REQ-021 ihit/dhit SHALL each be high exactly one cycle per completed access, never both in the same cycle.
REQ-022 In the cycle ihit (dhit) is high, IDLE SHALL ignore iREN (dREN/dWEN) for arbitration; the other requester may be granted.
REQ-023 Minimum latency: request seen in IDLE at cycle N, ram_ready at N+1 -> hit at N+2; back-to-back accesses every 2 cycles.
REQ-024 If the granted requester deasserts its request while in ACC, state SHALL return to IDLE next cycle with no hit and no load update.
REQ-025 ram_ready in IDLE SHALL be ignored.
REQ-026 iload/dload SHALL hold value until next completed read of their requester.

Reset
REQ-027 nRST low SHALL immediately force state IDLE, ihit=dhit=0, iload=dload=0, err=0, timeout counter 0, all RAM outputs 0, including mid-access (access aborted, no hit after release).

Configuration
REQ-028 Macro ARB_TIMEOUT_EN defined: 4-bit counter increments each ACC cycle without ram_ready, clears on state change; at TIMEOUT, state->IDLE, no hit, err<=1 (sticky until reset).
REQ-029 ARB_TIMEOUT_EN undefined: no counter; ACC waits indefinitely for ram_ready or request drop; err tied 0.

Verification
REQ-030 iREN=1, iaddr=0x40, ram_ready=1 one cycle after grant, ramload=0xDEADBEEF -> ramaddr=0x40 in IACC, ihit pulse at N+2, iload=0xDEADBEEF.
REQ-031 iREN and dWEN both high at cycle N, daddr=0x100, dstore=0x12345678 -> DACC first, ramWEN=1, dhit then IACC granted, ihit following; never simultaneous hits.
REQ-032 dREN held, ram_ready low 5 cycles then high with ramload=0xCAFE -> dhit exactly once at ready+1, dload=0xCAFE.
REQ-033 nRST pulsed low in DACC with ram_ready low -> all outputs 0 asynchronously, state IDLE, no dhit after release.
REQ-034 ARB_TIMEOUT_EN, TIMEOUT=15, iREN held, ram_ready never -> state IDLE after 15 IACC cycles, err=1 and stays 1, ihit never asserted; without macro err stays 0 and IACC persists.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester (instruction/data) arbiter for one single-port RAM; data wins ties. Optional ARB_TIMEOUT_EN aborts stalled accesses.
// Latency: grant one cycle after a request is seen in IDLE; hit and load registered one cycle after ram_ready.
// Backpressure: requesters hold iREN/dREN/dWEN until their hit; the ACC state waits on ram_ready, a dropped request or, when enabled, a timeout.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    input  logic        ram_ready,
    input  logic [31:0] ramload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    output logic        ihit,
    output logic        dhit,
    output logic [31:0] iload,
    output logic [31:0] dload,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        ihit_q, ihit_d;
    logic        dhit_q, dhit_d;
    logic [31:0] iload_q, iload_d;
    logic [31:0] dload_q, dload_d;
    logic        abort;

`ifdef ARB_TIMEOUT_EN
    localparam logic [3:0] TO_LAST = 4'(TIMEOUT - 1);
    logic [3:0] cnt_q, cnt_d;
    logic       err_q, err_d;

    // Fires on the TIMEOUT-th consecutive ACC cycle without ram_ready.
    assign abort = (state_q != IDLE) && !ram_ready && (cnt_q == TO_LAST);
`else
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT);
    assign abort = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ihit_d  = 1'b0;
        dhit_d  = 1'b0;
        iload_d = iload_q;
        dload_d = dload_q;
        case (state_q)
            IDLE: begin
                // A requester whose hit is showing this cycle is still holding its request.
                if ((dREN || dWEN) && !dhit_q) begin
                    state_d = DACC;
                end else if (iREN && !ihit_q) begin
                    state_d = IACC;
                end
            end
            IACC: begin
                if (!iREN) begin
                    state_d = IDLE;
                end else if (ram_ready) begin
                    state_d = IDLE;
                    ihit_d  = 1'b1;
                    iload_d = ramload;
                end else if (abort) begin
                    state_d = IDLE;
                end
            end
            DACC: begin
                if (!(dREN || dWEN)) begin
                    state_d = IDLE;
                end else if (ram_ready) begin
                    state_d = IDLE;
                    dhit_d  = 1'b1;
                    if (dREN) begin
                        dload_d = ramload;
                    end
                end else if (abort) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef ARB_TIMEOUT_EN
    always_comb begin
        err_d = err_q;
        cnt_d = cnt_q + 4'd1;
        if (state_q == IDLE || ram_ready || state_d != state_q) begin
            cnt_d = 4'd0;
        end
        if (abort && state_d == IDLE && !ram_ready &&
            ((state_q == IACC && iREN) || (state_q == DACC && (dREN || dWEN)))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_q <= 4'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            ihit_q  <= 1'b0;
            dhit_q  <= 1'b0;
            iload_q <= 32'd0;
            dload_q <= 32'd0;
        end else begin
            state_q <= state_d;
            ihit_q  <= ihit_d;
            dhit_q  <= dhit_d;
            iload_q <= iload_d;
            dload_q <= dload_d;
        end
    end

    // RAM strobes follow the state directly so ram_ready can land in the first ACC cycle.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'd0;
        ramstore = 32'd0;
        case (state_q)
            IACC: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
            end
            DACC: begin
                ramREN   = dREN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
            end
            default: ;
        endcase
    end

    assign ihit  = ihit_q;
    assign dhit  = dhit_q;
    assign iload = iload_q;
    assign dload = dload_q;

endmodule
